// File: rtl/result_packer.sv
`default_nettype none
// ============================================================================
// result_packer : packs DATA_W-bit results into MEM_WORD_SIZE-bit words with a
// lane mask; define RESULT_PACKER_MSB_FIRST_EN to fill lanes from the top down.
// Revision 1.0
// ============================================================================
module result_packer #(
  parameter int DATA_W        = 32,
  parameter int MEM_WORD_SIZE = 64
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           in_valid_i,
  output logic                           in_ready_o,
  input  logic [DATA_W-1:0]              result_i,
  input  logic                           flush_i,
  output logic                           out_valid_o,
  input  logic                           out_ready_i,
  output logic [MEM_WORD_SIZE-1:0]       buffer_o,
  output logic [MEM_WORD_SIZE/DATA_W-1:0] lane_mask_o
);

  localparam int LANES = MEM_WORD_SIZE / DATA_W;
  localparam int PTR_W = $clog2(LANES);
  localparam logic [PTR_W-1:0] c_last_lane = PTR_W'(LANES - 1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_PEND  = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [MEM_WORD_SIZE-1:0] r_asm;
  logic [LANES-1:0]         r_mask;
  logic [PTR_W-1:0]         r_ptr;
  logic [MEM_WORD_SIZE-1:0] r_buf;
  logic [LANES-1:0]         r_out_mask;
  logic                     r_out_valid;

  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_out_free;
  logic                     w_close;
  logic                     w_load;
  logic [PTR_W-1:0]         w_lane;
  logic [MEM_WORD_SIZE-1:0] w_asm_nxt;
  logic [LANES-1:0]         w_mask_nxt;

  // in_ready is a pure state decode so out_ready_i never reaches it combinationally
  always_comb begin
    w_in_ready = (r_state != S_PEND);
    w_accept   = in_valid_i && w_in_ready;
    w_out_free = !r_out_valid || out_ready_i;
`ifdef RESULT_PACKER_MSB_FIRST_EN
    w_lane     = c_last_lane - r_ptr;
`else
    w_lane     = r_ptr;
`endif
    w_asm_nxt  = r_asm;
    w_mask_nxt = r_mask;
    for (int k = 0; k < LANES; k++) begin
      if (w_accept && (w_lane == PTR_W'(k))) begin
        w_asm_nxt[k*DATA_W +: DATA_W] = result_i;
        w_mask_nxt[k]                 = 1'b1;
      end
    end
    w_close = w_in_ready &&
              ((w_accept && (r_ptr == c_last_lane)) ||
               (flush_i && ((r_state == S_FILL) || w_accept)));
    w_load  = w_out_free && (w_close || (r_state == S_PEND));
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_PEND) begin
      if (w_out_free) w_state_nxt = S_EMPTY;
    end else if (w_close) begin
      w_state_nxt = w_out_free ? S_EMPTY : S_PEND;
    end else if (w_accept) begin
      w_state_nxt = S_FILL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_EMPTY;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_asm       <= '0;
      r_mask      <= '0;
      r_ptr       <= '0;
      r_buf       <= '0;
      r_out_mask  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_load) begin
        r_buf       <= w_asm_nxt;
        r_out_mask  <= w_mask_nxt;
        r_out_valid <= 1'b1;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end

      // A closed word that cannot move yet stays in the assembly stage (PEND)
      if (w_load) begin
        r_asm  <= '0;
        r_mask <= '0;
        r_ptr  <= '0;
      end else if (w_close) begin
        r_asm  <= w_asm_nxt;
        r_mask <= w_mask_nxt;
        r_ptr  <= '0;
      end else if (w_accept) begin
        r_asm  <= w_asm_nxt;
        r_mask <= w_mask_nxt;
        r_ptr  <= r_ptr + PTR_W'(1);
      end
    end
  end

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = r_out_valid;
  assign buffer_o    = r_buf;
  assign lane_mask_o = r_out_mask;

endmodule
`default_nettype wire

// File: tb/tb_result_packer.sv
`default_nettype none
// ============================================================================
// tb_result_packer : table-driven vectors with a scoreboard of expected words.
// Revision 1.0
// ============================================================================
module tb_result_packer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] result_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] buffer_o;
  logic [1:0]  lane_mask_o;

  result_packer #(.DATA_W(32), .MEM_WORD_SIZE(64)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .result_i    (result_i),
    .flush_i     (flush_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .buffer_o    (buffer_o),
    .lane_mask_o (lane_mask_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] d;
    bit          f;
    bit          ordy;
    bit          exp_rdy;
    bit          exp_ov;
    bit          push;
    logic [63:0] w;
    logic [1:0]  m;
  } vec_t;

  typedef struct {
    logic [63:0] w;
    logic [1:0]  m;
  } word_t;

  vec_t  vecs[$];
  word_t exp_q[$];
  int    checks = 0;
  int    errors = 0;

  function automatic int lane(input int i);
`ifdef RESULT_PACKER_MSB_FIRST_EN
    return 1 - i;
`else
    return i;
`endif
  endfunction

  function automatic void add(input bit v, input logic [31:0] d, input bit f,
                              input bit o, input bit rdy, input bit ov,
                              input int n = 0, input logic [31:0] a = 32'h0,
                              input logic [31:0] b = 32'h0);
    vec_t x;
    x.v = v; x.d = d; x.f = f; x.ordy = o; x.exp_rdy = rdy; x.exp_ov = ov;
    x.push = (n != 0);
    x.w = '0;
    x.m = '0;
    if (n >= 1) begin x.w[lane(0)*32 +: 32] = a; x.m[lane(0)] = 1'b1; end
    if (n >= 2) begin x.w[lane(1)*32 +: 32] = b; x.m[lane(1)] = 1'b1; end
    vecs.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input vec_t x);
    word_t e;
    in_valid_i  = x.v;
    result_i    = x.d;
    flush_i     = x.f;
    out_ready_i = x.ordy;
    if (x.push) begin
      e.w = x.w;
      e.m = x.m;
      exp_q.push_back(e);
    end
    @(negedge clk);
    chk("in_ready", 64'(in_ready_o), 64'(x.exp_rdy));
    chk("out_valid", 64'(out_valid_o), 64'(x.exp_ov));
    @(posedge clk);
    #1;
  endtask

  // Words are compared on handshake; a held word must match the queue head.
  always @(negedge clk) begin
    if (rst_ni && out_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got %h mask %b expected none at %0t",
                 buffer_o, lane_mask_o, $time);
      end else if (out_ready_i) begin
        chk("word_data", buffer_o, exp_q[0].w);
        chk("word_mask", 64'(lane_mask_o), 64'(exp_q[0].m));
        void'(exp_q.pop_front());
      end else begin
        chk("held_data", buffer_o, exp_q[0].w);
        chk("held_mask", 64'(lane_mask_o), 64'(exp_q[0].m));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    word_t e;
    rst_ni = 1'b0; in_valid_i = 1'b0; result_i = '0; flush_i = 1'b0; out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_buffer", buffer_o, 64'd0);
    chk("rst_mask", 64'(lane_mask_o), 64'd0);
    chk("rst_in_ready", 64'(in_ready_o), 64'd1);
    rst_ni = 1'b1;

    // back-to-back fill, then flush in EMPTY must not emit
    add(1, 32'h11111111, 0, 1, 1, 0);
    add(1, 32'h22222222, 0, 1, 1, 0, 2, 32'h11111111, 32'h22222222);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 1, 0);
    // flush with same-cycle accept
    add(1, 32'hAAAA5555, 1, 1, 1, 0, 1, 32'hAAAA5555);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 1, 0);
    // backpressure: 6 offered, 4 absorbed
    for (int i = 0; i < 6; i++) begin
      if (i == 1)      add(1, 32'hB0000001, 0, 0, 1, 0, 2, 32'hB0000000, 32'hB0000001);
      else if (i == 3) add(1, 32'hB0000003, 0, 0, 1, 1, 2, 32'hB0000002, 32'hB0000003);
      else             add(1, 32'hB0000000 | 32'(i), 0, 0, (i < 4), (i >= 2));
    end
    add(0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 1, 1, 0);
    // continuous stream of 8
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 1)
        add(1, 32'hC0000000 | 32'(i), 0, 1, 1, (i >= 2) && (i % 2 == 0), 2,
            32'hC0000000 | 32'(i - 1), 32'hC0000000 | 32'(i));
      else
        add(1, 32'hC0000000 | 32'(i), 0, 1, 1, (i >= 2));
    end
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 1, 1, 0);

    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // reset mid-operation: a held word plus a partial are discarded
    in_valid_i = 1'b1; flush_i = 1'b0; out_ready_i = 1'b0; result_i = 32'h12345678;
    @(posedge clk); #1;
    result_i = 32'h9ABCDEF0;
    e.w = '0; e.m = '0;
    e.w[lane(0)*32 +: 32] = 32'h12345678; e.m[lane(0)] = 1'b1;
    e.w[lane(1)*32 +: 32] = 32'h9ABCDEF0; e.m[lane(1)] = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    result_i = 32'h55555555;
    @(posedge clk); #1;
    chk("pre_reset_valid", 64'(out_valid_o), 64'd1);
    #2;
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid_o), 64'd0);
    chk("async_rst_buffer", buffer_o, 64'd0);
    chk("async_rst_mask", 64'(lane_mask_o), 64'd0);
    chk("async_rst_ready", 64'(in_ready_o), 64'd1);
    exp_q.delete();
    @(posedge clk); #1;
    rst_ni = 1'b1;

    vecs.delete();
    add(1, 32'h01010101, 0, 1, 1, 0);
    add(1, 32'h02020202, 0, 1, 1, 0, 2, 32'h01010101, 32'h02020202);
    add(0, 0, 0, 1, 1, 1);
    add(0, 0, 0, 1, 1, 0);
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/result_packer.md
# result_packer

Parametrised successor to the two-slot result buffer. Packs a stream of `DATA_W`-bit ALU results into `MEM_WORD_SIZE`-bit memory words, filling lanes automatically. Uses valid/ready handshakes on both sides and can flush a partially filled word with a lane mask. Sits between the ALU result path and the memory write port of the calculator datapath.

## Interface
Parameters:
- `DATA_W`, default `calculator_pkg::DATA_W` (32): width of one result.
- `MEM_WORD_SIZE`, default `calculator_pkg::MEM_WORD_SIZE` (64): width of one output word. Must be an integer multiple of `DATA_W`, with a ratio of at least 2.
- `LANES` (localparam) = `MEM_WORD_SIZE/DATA_W`.

Ports:
- `clk_i`  in  1  clock; all state updates on posedge.
- `rst_ni`  in  1  reset, **asynchronous, active-low**.
- `in_valid_i`  in  1  a result is presented.
- `in_ready_o`  out  1  the packer can accept a result.
- `result_i`  in  `DATA_W`  result data.
- `flush_i`  in  1  single-cycle request to close the current partial word.
- `out_valid_o`  out  1  `buffer_o` holds a word.
- `out_ready_i`  in  1  the consumer takes the word.
- `buffer_o`  out  `MEM_WORD_SIZE`  packed word.
- `lane_mask_o`  out  `LANES`  bit k set means lane k holds valid data.

## Operation
- Storage is split in two:
  - Assembly stage: `asm_q`, lane pointer `ptr_q` (range 0..LANES-1), `asm_mask_q`.
  - Output register: `buffer_o`, `lane_mask_o`, `out_valid_o`.
- Accept means `in_valid_i && in_ready_o`. An accepted result is written to lane `ptr_q` (bits `[ptr*DATA_W +: DATA_W]`), the lane's mask bit is set, and `ptr_q` increments.
- FSM states:
  - EMPTY: `ptr_q`=0, mask all zero.
  - FILL: 1..LANES-1 lanes filled.
  - PEND: the word is closed but the output register is occupied.
- **Close event**: an accept into lane LANES-1, or `flush_i` while in FILL. A `flush_i` in the same cycle as an accept includes that accepted result.
- **Output register free**: `!out_valid_o || out_ready_i`.
- On a close event:
  - If the output register is free, the word and mask move to the output register, the assembly stage clears, and the FSM goes to EMPTY.
  - Otherwise the FSM goes to PEND.
- In PEND:
  - `in_ready_o`=0 and `flush_i` is ignored.
  - When `out_ready_i` is high, the pending word transfers into the output register, the assembly stage clears, and the FSM goes to EMPTY.
- `in_ready_o` is 1 in EMPTY and FILL and 0 in PEND. It is a registered-state decode with no combinational path from `out_ready_i`.
- `flush_i` in EMPTY with no accept is a no-op; no empty word is ever emitted.
- Unfilled lanes of a flushed word read as 0.
- After a handshake, `out_valid_o` drops unless a new word loads in the same cycle.

## Timing
- Reset (async assert, sync-safe deassert) leaves every output at 0 and `in_ready_o`=1:
  - `out_valid_o`=0, `buffer_o`=0, `lane_mask_o`=0.
  - FSM EMPTY, `ptr_q`=0, `asm_q`=0.
- Reset mid-operation discards any partial and pending words.
- Latency: a close event at edge N gives `out_valid_o`=1 after edge N, when the output register is free.
- Throughput: one result per cycle sustained while `out_ready_i`=1. There are no bubbles at word boundaries.
- `buffer_o` and `lane_mask_o` are stable while `out_valid_o`=1 and `out_ready_i`=0.
- Backpressure: with `out_ready_i`=0 the block absorbs exactly one held word plus one full assembly word, then holds `in_ready_o`=0.

## Configuration
- `RESULT_PACKER_MSB_FIRST_EN`:
  - Defined: the lane order is reversed. The first result of a word goes to the top lane (bits `[MEM_WORD_SIZE-1 -: DATA_W]`), and `lane_mask_o` bit k refers to the same reversed lane.
  - Undefined: the first result goes to lane 0, the LSBs.
- Handshake and timing are identical in both builds.

## Test plan
Defaults used throughout: `DATA_W`=32, `MEM_WORD_SIZE`=64.
- Back-to-back fill: accept `0x11111111` then `0x22222222` with `out_ready_i`=1 → `buffer_o`=`0x22222222_11111111`, mask `2'b11`, `out_valid_o` high one cycle after the second accept.
- Flush partial: accept `0xAAAA5555` with `flush_i`=1 in the same cycle → `buffer_o`=`0x00000000_AAAA5555`, mask `2'b01`. A later `flush_i` in EMPTY produces no `out_valid_o`.
- Backpressure: `out_ready_i`=0, stream 6 results → exactly 4 accepted, `in_ready_o`=0 from then on, `buffer_o` stable. Raise `out_ready_i` → words `{r1,r0}` then `{r3,r2}` in order, and `in_ready_o` returns to 1 the cycle after the PEND transfer.
- Continuous stream of 8 results with `out_ready_i`=1 → 4 words, no `in_ready_o` deassertion.
- Reset mid-word: accept one result, pull `rst_ni` low asynchronously → all outputs 0 immediately. After release, the next two results form a fresh word with mask `2'b11`.
- MSB-first build: accept `0x11111111`, `0x22222222` → `buffer_o`=`0x11111111_22222222`. Flushing one result `0x33333333` → `0x33333333_00000000`, mask `2'b10`.
